// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux scheduler.
//   NUM_DEST : number of demux destinations
//   SEL_W    : width of the demux select
//   state_t  : scheduler FSM states
//   onehot4  : select index to one-hot destination valid
package demux_sched_pkg;

  localparam int unsigned NUM_DEST = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRoute,
    StDrain,
    StDone
  } state_t;

  function automatic logic [NUM_DEST-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_DEST-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_sched_cnt.sv
// Beat / destination / destination-count counters for the demux scheduler.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   clear            zero all counters (abort)
//   load             start of run: zero beat/dcnt, load dest with first_dest
//   first_dest       first destination of the run
//   advance          one vector accepted
//   cfg_len          latched burst length (vectors per destination)
//   cfg_num_dest     latched destinations per run minus 1
//   dest             destination for the vector being accepted
//   last_beat        the vector being accepted is the last one of the run
module demux_sched_cnt
  import demux_sched_pkg::*;
#(
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [SEL_W-1:0]   first_dest,
  input  logic               advance,
  input  logic [BURST_W-1:0] cfg_len,
  input  logic [1:0]         cfg_num_dest,
  output logic [SEL_W-1:0]   dest,
  output logic               last_beat
);

  logic [BURST_W-1:0] beat_q, beat_d;
  logic [SEL_W-1:0]   dest_q, dest_d;
  logic [1:0]         dcnt_q, dcnt_d;
  logic               beat_end;

  // cfg_len is never 0 while advancing: a zero-length run skips routing.
  assign beat_end = (beat_q == (cfg_len - BURST_W'(1)));

  always_comb begin
    beat_d = beat_q;
    dest_d = dest_q;
    dcnt_d = dcnt_q;
    if (clear) begin
      beat_d = '0;
      dest_d = '0;
      dcnt_d = '0;
    end else if (load) begin
      beat_d = '0;
      dest_d = first_dest;
      dcnt_d = '0;
    end else if (advance) begin
      if (beat_end) begin
        beat_d = '0;
        dest_d = dest_q + SEL_W'(1);  // wraps 3 -> 0
        dcnt_d = dcnt_q + 2'd1;
      end else begin
        beat_d = beat_q + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      dest_q <= '0;
      dcnt_q <= '0;
    end else begin
      beat_q <= beat_d;
      dest_q <= dest_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign dest      = dest_q;
  assign last_beat = beat_end && (dcnt_q == cfg_num_dest);

endmodule

// File: rtl/demux_scheduler.sv
// Sequencer for the 4-way lane demux in front of the CNN PE rows. Each accepted vector is held
// in one output register stage and steered to the current destination; each destination gets
// cfg_burst_len vectors, and a run covers cfg_num_dest+1 destinations.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, abort                  run control (abort wins over everything)
//   cfg_burst_len/num_dest/first  run config, latched on an accepted start
//   in_data, in_valid, in_ready   input vector stream
//   out_data, sel, out_valid      registered vector, demux select, one-hot valid
//   out_ready                     per-destination ready (only out_ready[sel] is used)
//   busy, done                    run in progress, end-of-run pulse
//   stall_cnt                     only with DEMUX_SCHED_PERF_EN: output-stall cycle counter
module demux_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 9,
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned BURST_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [BURST_W-1:0]              cfg_burst_len,
  input  logic [1:0]                      cfg_num_dest,
  input  logic [SEL_W-1:0]                cfg_first_dest,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] out_data,
  output logic [SEL_W-1:0]                sel,
  output logic [NUM_DEST-1:0]             out_valid,
  input  logic [NUM_DEST-1:0]             out_ready,
  output logic                            busy,
  output logic                            done
`ifdef DEMUX_SCHED_PERF_EN
  ,
  output logic [31:0]                     stall_cnt
`endif
);

  localparam int unsigned DataW = ARRAY_SIZE * DATA_SIZE;

  state_t             state_q, state_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [1:0]         num_dest_q, num_dest_d;
  logic [DataW-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               ov_q, ov_d;

  logic             start_acc;
  logic             xfer;
  logic             drain;
  logic [SEL_W-1:0] dest;
  logic             last_beat;

  assign start_acc = start && (state_q == StIdle) && !abort;
  assign xfer      = in_valid && in_ready;
  assign drain     = ov_q && out_ready[sel_q];

  demux_sched_cnt #(
    .BURST_W(BURST_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear       (abort),
    .load        (start_acc),
    .first_dest  (cfg_first_dest),
    .advance     (xfer),
    .cfg_len     (len_q),
    .cfg_num_dest(num_dest_q),
    .dest        (dest),
    .last_beat   (last_beat)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = (cfg_burst_len == '0) ? StDone : StRoute;
          end
        end
        StRoute: begin
          if (xfer && last_beat) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (!ov_q || drain) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    in_ready  = (state_q == StRoute) && !abort && (!ov_q || out_ready[sel_q]);
    out_valid = ov_q ? onehot4(sel_q) : '0;
  end

  // Config latch and output register
  always_comb begin
    len_d      = len_q;
    num_dest_d = num_dest_q;
    out_data_d = out_data_q;
    sel_d      = sel_q;
    ov_d       = ov_q;
    if (start_acc) begin
      len_d      = cfg_burst_len;
      num_dest_d = cfg_num_dest;
    end
    if (abort) begin
      ov_d = 1'b0;
    end else if (xfer) begin
      // sel only moves on a load, so it never changes under a held out_valid.
      out_data_d = in_data;
      sel_d      = dest;
      ov_d       = 1'b1;
    end else if (drain) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      num_dest_q <= '0;
      out_data_q <= '0;
      sel_q      <= '0;
      ov_q       <= 1'b0;
    end else begin
      len_q      <= len_d;
      num_dest_q <= num_dest_d;
      out_data_q <= out_data_d;
      sel_q      <= sel_d;
      ov_q       <= ov_d;
    end
  end

  assign out_data = out_data_q;
  assign sel      = sel_q;

`ifdef DEMUX_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (ov_q && !out_ready[sel_q] && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
